// File: rtl/cpu_clock_ctrl_pkg.sv
// cpu_clock_ctrl_pkg: state codes and default debounce constants for the CPU clock controller.
package cpu_clock_ctrl_pkg;
    typedef enum logic [1:0] {
        S_STOP = 2'd0,
        S_RUN  = 2'd1,
        S_STEP = 2'd2,
        S_HLT  = 2'd3
    } state_t;
    localparam int DEB_WIDTH_DEF  = 20;
    localparam int DEB_CYCLES_DEF = 500000;
endpackage

// File: rtl/cpu_clock_ctrl_if.sv
// cpu_clock_ctrl_if: control/status bundle between the environment (master) and the clock controller (slave).
// FAST exists only when CPU_CLOCK_CTRL_FAST_RUN_EN is defined.
interface cpu_clock_ctrl_if;
    logic       T4hz;
    logic       RUN_SW;
    logic       STEP_BTN;
    logic       HLT;
    logic       CPU_CE;
    logic       RUNNING;
    logic       HALTED;
    logic [7:0] CYC_CNT;
`ifdef CPU_CLOCK_CTRL_FAST_RUN_EN
    logic       FAST;
    modport master (output T4hz, RUN_SW, STEP_BTN, HLT, FAST, input CPU_CE, RUNNING, HALTED, CYC_CNT);
    modport slave  (input T4hz, RUN_SW, STEP_BTN, HLT, FAST, output CPU_CE, RUNNING, HALTED, CYC_CNT);
`else
    modport master (output T4hz, RUN_SW, STEP_BTN, HLT, input CPU_CE, RUNNING, HALTED, CYC_CNT);
    modport slave  (input T4hz, RUN_SW, STEP_BTN, HLT, output CPU_CE, RUNNING, HALTED, CYC_CNT);
`endif
endinterface

// File: rtl/cpu_clock_ctrl_btn_debounce.sv
// btn_debounce: 2-flop synchronizer plus counter debouncer; level changes after DEB_CYCLES
// consecutive differing samples, rise pulses for one cycle on an accepted 0->1 change.
module btn_debounce
    import cpu_clock_ctrl_pkg::*;
#(
    parameter int DEB_WIDTH  = DEB_WIDTH_DEF,
    parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
    input  logic CLK,
    input  logic CLR,
    input  logic btn_in,
    output logic level,
    output logic rise
);
    logic [1:0]           sync_q;
    logic [DEB_WIDTH-1:0] cnt_q;
    logic                 level_q;
    logic                 rise_q;
    logic                 differ;
    logic                 accept;

    assign differ = sync_q[1] ^ level_q;
    assign accept = differ && (cnt_q == DEB_WIDTH'(DEB_CYCLES - 1));
    assign level  = level_q;
    assign rise   = rise_q;

    always_ff @(posedge CLK) begin
        if (CLR) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], btn_in};
            cnt_q   <= (differ && !accept) ? cnt_q + DEB_WIDTH'(1) : '0;
            level_q <= accept ? sync_q[1] : level_q;
            rise_q  <= accept && sync_q[1];
        end
    end
endmodule

// File: rtl/cpu_clock_ctrl.sv
// cpu_clock_ctrl: run/step/halt controller turning T4hz rising edges into one-cycle CPU_CE pulses.
// Optional CPU_CLOCK_CTRL_FAST_RUN_EN adds FAST: pulse every cycle while running.
module cpu_clock_ctrl
    import cpu_clock_ctrl_pkg::*;
#(
    parameter int DEB_WIDTH  = DEB_WIDTH_DEF,
    parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
    input logic             CLK,
    input logic             CLR,
    cpu_clock_ctrl_if.slave bus
);
    state_t     state_q, state_d;
    logic       t_q;
    logic       ce_q, ce_d;
    logic       running_q, halted_q;
    logic [7:0] cnt_q;
    logic       tick;
    logic       step_level, step_rise, step_req;
    logic       fast;

`ifdef CPU_CLOCK_CTRL_FAST_RUN_EN
    assign fast = bus.FAST;
`else
    assign fast = 1'b0;
`endif

    btn_debounce #(.DEB_WIDTH(DEB_WIDTH), .DEB_CYCLES(DEB_CYCLES)) u_deb (
        .CLK   (CLK),
        .CLR   (CLR),
        .btn_in(bus.STEP_BTN),
        .level (step_level),
        .rise  (step_rise)
    );

    assign tick     = bus.T4hz & ~t_q;
    assign step_req = step_rise & step_level;

    always_comb begin
        state_d = (state_q == S_STOP) ? (bus.HLT ? S_HLT : bus.RUN_SW ? S_RUN : step_req ? S_STEP : S_STOP) :
                  (state_q == S_RUN)  ? (bus.HLT ? S_HLT : !bus.RUN_SW ? S_STOP : S_RUN) :
                  (state_q == S_STEP) ? (bus.HLT ? S_HLT : tick ? S_STOP : S_STEP) : S_HLT;
        ce_d    = (state_q == S_RUN  && !bus.HLT && bus.RUN_SW && (tick || fast)) ||
                  (state_q == S_STEP && !bus.HLT && tick);
    end

    always_ff @(posedge CLK) begin
        if (CLR) begin
            state_q   <= S_STOP;
            t_q       <= 1'b0;
            ce_q      <= 1'b0;
            running_q <= 1'b0;
            halted_q  <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            t_q       <= bus.T4hz;
            ce_q      <= ce_d;
            running_q <= state_d == S_RUN;
            halted_q  <= state_d == S_HLT;
            cnt_q     <= cnt_q + 8'(ce_d);
        end
    end

    assign bus.CPU_CE  = ce_q;
    assign bus.RUNNING = running_q;
    assign bus.HALTED  = halted_q;
    assign bus.CYC_CNT = cnt_q;
endmodule

// File: tb/tb_cpu_clock_ctrl.sv
// tb_cpu_clock_ctrl: scoreboard bench for cpu_clock_ctrl; stimulus queues expected pulses, a monitor checks them.
module tb_cpu_clock_ctrl;
    logic CLK = 1'b0;
    logic CLR;
    always #5 CLK = ~CLK;

    cpu_clock_ctrl_if bus();
    cpu_clock_ctrl #(.DEB_WIDTH(8), .DEB_CYCLES(4)) dut (.CLK(CLK), .CLR(CLR), .bus(bus));

    typedef struct {
        int         cyc;
        logic [7:0] cnt;
    } exp_t;

    exp_t       q[$];
    exp_t       mon_e;
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_cnt = 8'd0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(negedge CLK) begin
        if (bus.CPU_CE === 1'b1) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse: got pulse at cycle %0d cnt %0d expected none", cyc, bus.CYC_CNT);
            end else begin
                mon_e = q.pop_front();
                chk("pulse_cycle", cyc, mon_e.cyc);
                chk("pulse_cnt", 32'(bus.CYC_CNT), 32'(mon_e.cnt));
            end
        end
    end

    task automatic tick(input bit pulse, input int half);
        bus.T4hz = 1'b1;
        if (pulse) begin
            exp_cnt = exp_cnt + 8'd1;
            q.push_back('{cyc: cyc + 1, cnt: exp_cnt});
        end
        repeat (half) @(negedge CLK);
        bus.T4hz = 1'b0;
        repeat (half) @(negedge CLK);
    endtask

    task automatic press(input int hold);
        bus.STEP_BTN = 1'b1;
        repeat (hold) @(negedge CLK);
        bus.STEP_BTN = 1'b0;
        repeat (10) @(negedge CLK);
    endtask

    task automatic do_reset();
        chk("queue_empty_before_reset", q.size(), 0);
        CLR = 1'b1;
        repeat (2) @(negedge CLK);
        CLR = 1'b0;
        exp_cnt = 8'd0;
    endtask

    initial begin
        int seq[3] = '{255, 0, 1};
        bus.T4hz = 1'b0;
        bus.RUN_SW = 1'b1;
        bus.STEP_BTN = 1'b0;
        bus.HLT = 1'b0;
`ifdef CPU_CLOCK_CTRL_FAST_RUN_EN
        bus.FAST = 1'b0;
`endif
        CLR = 1'b1;
        // reset holds everything low even with T4hz toggling and RUN_SW high
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            bus.T4hz = ~bus.T4hz;
            chk("rst_ce", 32'(bus.CPU_CE), 0);
            chk("rst_running", 32'(bus.RUNNING), 0);
            chk("rst_halted", 32'(bus.HALTED), 0);
            chk("rst_cnt", 32'(bus.CYC_CNT), 0);
        end
        bus.RUN_SW = 1'b0;
        bus.T4hz = 1'b0;
        CLR = 1'b0;
        tick(1'b0, 3);
        chk("stop_running", 32'(bus.RUNNING), 0);
        chk("stop_halted", 32'(bus.HALTED), 0);

        bus.RUN_SW = 1'b1;
        @(negedge CLK);
        chk("run_running", 32'(bus.RUNNING), 1);
        for (int i = 0; i < 5; i++) tick(1'b1, 10);
        chk("run_cnt5", 32'(bus.CYC_CNT), 5);
        chk("run_still", 32'(bus.RUNNING), 1);

        bus.T4hz = 1'b1;
        bus.RUN_SW = 1'b0;
        @(negedge CLK);
        chk("drop_running", 32'(bus.RUNNING), 0);
        bus.T4hz = 1'b0;
        repeat (9) @(negedge CLK);
        chk("drop_cnt", 32'(bus.CYC_CNT), 5);
        tick(1'b0, 10);

        bus.RUN_SW = 1'b1;
        @(negedge CLK);
        chk("hlt_pre_running", 32'(bus.RUNNING), 1);
        bus.HLT = 1'b1;
        @(negedge CLK);
        bus.HLT = 1'b0;
        chk("hlt_halted", 32'(bus.HALTED), 1);
        chk("hlt_running", 32'(bus.RUNNING), 0);
        for (int i = 0; i < 10; i++) begin
            tick(1'b0, 10);
            if (i == 4) press(8);
        end
        chk("hlt_stays", 32'(bus.HALTED), 1);
        chk("hlt_cnt", 32'(bus.CYC_CNT), 5);
        bus.RUN_SW = 1'b0;
        do_reset();
        @(negedge CLK);
        chk("clr_halted", 32'(bus.HALTED), 0);
        chk("clr_running", 32'(bus.RUNNING), 0);
        chk("clr_cnt", 32'(bus.CYC_CNT), 0);

        // bounces shorter than the debounce window must not produce a step
        repeat (3) begin
            bus.STEP_BTN = 1'b1;
            repeat (2) @(negedge CLK);
            bus.STEP_BTN = 1'b0;
            repeat (2) @(negedge CLK);
        end
        press(10);
        chk("step_running", 32'(bus.RUNNING), 0);
        chk("step_nopulse_yet", 32'(bus.CYC_CNT), 0);
        press(10);
        tick(1'b1, 10);
        chk("step_cnt1", 32'(bus.CYC_CNT), 1);
        tick(1'b0, 10);
        chk("step_no_queue", 32'(bus.CYC_CNT), 1);

        do_reset();
        bus.RUN_SW = 1'b1;
        @(negedge CLK);
        for (int i = 0; i < 254; i++) tick(1'b1, 2);
        chk("preload_cnt", 32'(bus.CYC_CNT), 254);
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, 2);
            chk("wrap_seq", 32'(bus.CYC_CNT), seq[i]);
        end
`ifdef CPU_CLOCK_CTRL_FAST_RUN_EN
        bus.FAST = 1'b1;
        for (int i = 0; i < 8; i++) begin
            exp_cnt = exp_cnt + 8'd1;
            q.push_back('{cyc: cyc + 1, cnt: exp_cnt});
            @(negedge CLK);
        end
        bus.FAST = 1'b0;
        repeat (3) @(negedge CLK);
        chk("fast_cnt", 32'(bus.CYC_CNT), 9);
`endif
        bus.RUN_SW = 1'b0;
        repeat (5) @(negedge CLK);
        chk("queue_drained", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
